axi_read_arbiter: RTL

- Shares the single AXI4 read channel pair (AR/R) of the core's `m_axi` port between NUM_REQ requesters, e.g. instruction fetch (index 0) and data/load path (index 1).
- Arbitrates AR requests round-robin and tags each with ARID = requester index. Routes R beats back by RID.
- Bounds in-flight transactions per requester.
- Output must satisfy the axi4_basic_props checks: stable ARVALID/payload until ARREADY, no illegal responses consumed silently.

---
 rtl/axi_read_arbiter_pkg.sv | 18 +
 rtl/axi_read_arbiter_rr_select.sv | 33 +++
 rtl/axi_read_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/axi_read_arbiter_pkg.sv
// Shared types and AXI constants for the read-channel arbiter.
// The write-side arbiter is meant to reuse these as well.
package axi_read_arbiter_pkg;

  localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
  } axi_rd_req_t;

  typedef enum logic {
    AR_IDLE,
    AR_ISSUE
  } ar_state_e;

endpackage

// File: rtl/axi_read_arbiter_rr_select.sv
// Round-robin priority select: the first set request at or after ptr_i, wrapping.
// Produces a one-hot grant, the binary index of the winner, and an any-request flag.
module rr_priority_select #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         grant_o,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 any_o
);

  localparam int IW = $clog2(N);

  function automatic logic [IW-1:0] wrap(input int v);
    return IW'(v % N);
  endfunction

  // NOTE: every output gets a default before the loop so no path leaves one unassigned (no latch).
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any_o && req_i[wrap(int'(ptr_i) + k)]) begin
        any_o                            = 1'b1;
        idx_o                            = wrap(int'(ptr_i) + k);
        grant_o[wrap(int'(ptr_i) + k)]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one AXI4 AR/R channel pair between NUM_REQ requesters: round-robin AR
// issue tagged with ARID = requester index, R beats routed back by RID.
module axi_read_arbiter
  import axi_read_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int MAX_OUT = 4,
  parameter int ID_W    = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*32-1:0]  req_addr,
  input  logic [NUM_REQ*8-1:0]   req_len,
  output logic [NUM_REQ-1:0]     resp_valid,
  input  logic [NUM_REQ-1:0]     resp_ready,
  output logic [31:0]            resp_data,
  output logic                   resp_last,
  output logic                   resp_err,
  output logic                   m_axi_arvalid,
  input  logic                   m_axi_arready,
  output logic [31:0]            m_axi_araddr,
  output logic [7:0]             m_axi_arlen,
  output logic [ID_W-1:0]        m_axi_arid,
  output logic [2:0]             m_axi_arsize,
  output logic [1:0]             m_axi_arburst,
  input  logic                   m_axi_rvalid,
  output logic                   m_axi_rready,
  input  logic [31:0]            m_axi_rdata,
  input  logic [1:0]             m_axi_rresp,
  input  logic                   m_axi_rlast,
  input  logic [ID_W-1:0]        m_axi_rid
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);

  ar_state_e          state_q;
  logic               arvalid_q;
  axi_rd_req_t        ar_q;
  logic [IDX_W-1:0]   ar_idx_q;
  logic [NUM_REQ-1:0] req_ready_q;
  logic [IDX_W-1:0]   rr_q;
  logic [CNT_W-1:0]   cnt_q [NUM_REQ];
  logic [CNT_W-1:0]   cnt_d [NUM_REQ];
  logic               err_q, err_d;

  axi_rd_req_t        req_in [NUM_REQ];
  logic [NUM_REQ-1:0] eligible, grant, inc, dec;
  logic [IDX_W-1:0]   win_idx, rid_idx;
  logic               win_any, ar_hs, r_hs, rid_ok;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_in[i].addr = req_addr[32*i +: 32];
      req_in[i].len  = req_len[8*i +: 8];
      eligible[i]    = req_valid[i] && (cnt_q[i] != CNT_MAX);
    end
  end

  rr_priority_select #(.N(NUM_REQ)) u_rr_select (
    .req_i   (eligible),
    .ptr_i   (rr_q),
    .grant_o (grant),
    .idx_o   (win_idx),
    .any_o   (win_any)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= AR_IDLE;
      arvalid_q   <= 1'b0;
      ar_q        <= '0;
      ar_idx_q    <= '0;
      req_ready_q <= '0;
      rr_q        <= '0;
    end else begin
      req_ready_q <= '0;
      case (state_q)
        AR_IDLE: if (win_any) begin
          req_ready_q <= grant;
          ar_q        <= req_in[win_idx];
          ar_idx_q    <= win_idx;
          arvalid_q   <= 1'b1;
          state_q     <= AR_ISSUE;
        end
        AR_ISSUE: if (m_axi_arready) begin
          arvalid_q <= 1'b0;
          rr_q      <= IDX_W'((int'(ar_idx_q) + 1) % NUM_REQ);
          state_q   <= AR_IDLE;
        end
        default: state_q <= AR_IDLE;
      endcase
    end
  end

  // Extra bit on the compare so NUM_REQ == 2**ID_W does not wrap to zero.
  assign rid_ok  = {1'b0, m_axi_rid} < (ID_W + 1)'(NUM_REQ);
  assign rid_idx = m_axi_rid[IDX_W-1:0];
  assign ar_hs   = arvalid_q && m_axi_arready;
  assign r_hs    = m_axi_rvalid && m_axi_rready;

  always_comb begin
    m_axi_rready = rid_ok ? resp_ready[rid_idx] : 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      resp_valid[i] = m_axi_rvalid && (m_axi_rid == ID_W'(i));
      inc[i]        = ar_hs && (ar_idx_q == IDX_W'(i));
      dec[i]        = r_hs && m_axi_rlast && rid_ok && (rid_idx == IDX_W'(i));
    end
  end

  // Underflow flags an error and pins the counter at zero rather than wrapping.
  always_comb begin
    err_d = err_q;
    if (r_hs && (!rid_ok || m_axi_rresp != 2'b00)) err_d = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (dec[i] && cnt_q[i] == '0) err_d = 1'b1;
      if (inc[i] && !dec[i])                            cnt_d[i] = cnt_q[i] + 1'b1;
      else if (dec[i] && !inc[i] && cnt_q[i] != '0)     cnt_d[i] = cnt_q[i] - 1'b1;
    end
  end

  // NOTE: the counter array is a handful of flops, not RAM, so it is reset with everything else.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_araddr  = ar_q.addr;
  assign m_axi_arlen   = ar_q.len;
  assign m_axi_arid    = ID_W'(ar_idx_q);
  assign m_axi_arsize  = AXI_SIZE_WORD;
  assign m_axi_arburst = AXI_BURST_INCR;
  assign resp_data     = m_axi_rdata;
  assign resp_last     = m_axi_rlast;
  assign resp_err      = err_q;

endmodule
